// File: rtl/keypad_entry.sv
// Keypad entry buffer: edge-detects key presses, builds a BCD number and hands it off over valid/ready.
// Optional idle auto-clear is enabled by defining KEYPAD_ENTRY_TIMEOUT_EN.
module keypad_entry #(
    parameter int DIGITS         = 4,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [3:0]                   enc_out,
    input  logic                         pressed,
    output logic [4*DIGITS-1:0]          disp_digits,
    output logic [$clog2(DIGITS+1)-1:0]  digit_count,
    output logic [4*DIGITS-1:0]          entry_value,
    output logic                         entry_valid,
    input  logic                         entry_ready,
    output logic                         key_err,
    output logic                         timeout,
    output logic [1:0]                   dbg_state
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] MAXC = CW'(DIGITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Handshake: entry_value is offered while entry_valid=1 and is consumed
    // on the first clk edge where entry_valid=1 and entry_ready=1.

    state_t          r_state;
    logic            r_pressed_d;
    logic [BW-1:0]   r_buf;
    logic [CW-1:0]   r_cnt;
    logic [BW-1:0]   r_val;
    logic            r_valid;
    logic            r_err;
    logic            r_to;

    state_t          w_state_nxt;
    logic [BW-1:0]   w_buf_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [BW-1:0]   w_val_nxt;
    logic            w_valid_nxt;
    logic            w_err_nxt;
    logic            w_to_nxt;
    logic            w_key_stb;
    logic            w_to_hit;

    assign w_key_stb = pressed & ~r_pressed_d;

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_idle_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_cnt <= '0;
        end else if (r_state == ENTRY && w_state_nxt == ENTRY && !w_key_stb) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end else begin
            r_idle_cnt <= '0;
        end
    end

    assign w_to_hit = (r_state == ENTRY) && (r_idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign w_to_hit = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_cnt_nxt   = r_cnt;
        w_val_nxt   = r_val;
        w_valid_nxt = r_valid;
        w_err_nxt   = 1'b0;
        w_to_nxt    = 1'b0;
        case (r_state)
            DONE: begin
                // Keys are never queued behind a pending entry.
                if (w_key_stb) w_err_nxt = 1'b1;
                if (entry_ready) begin
                    w_valid_nxt = 1'b0;
                    w_buf_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                if (w_key_stb) begin
                    if (enc_out <= 4'h9) begin
                        if (r_cnt != MAXC) begin
                            w_buf_nxt   = (r_buf << 4) | BW'(enc_out);
                            w_cnt_nxt   = r_cnt + 1'b1;
                            w_state_nxt = ENTRY;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end else begin
                        case (enc_out)
                            4'hA: begin
                                if (r_cnt != '0) begin
                                    w_buf_nxt = r_buf >> 4;
                                    w_cnt_nxt = r_cnt - 1'b1;
                                    if (r_cnt == CW'(1)) w_state_nxt = IDLE;
                                end else begin
                                    w_err_nxt = 1'b1;
                                end
                            end
                            4'hB: begin
                                w_buf_nxt   = '0;
                                w_cnt_nxt   = '0;
                                w_state_nxt = IDLE;
                            end
                            4'hE: begin
                                if (r_cnt == '0) begin
                                    w_err_nxt = 1'b1;
                                end else begin
                                    w_val_nxt   = r_buf;
                                    w_valid_nxt = 1'b1;
                                    w_state_nxt = DONE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end else if (w_to_hit) begin
                    w_buf_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_to_nxt    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pressed_d <= 1'b1;
            r_buf       <= '0;
            r_cnt       <= '0;
            r_val       <= '0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_to        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pressed_d <= pressed;
            r_buf       <= w_buf_nxt;
            r_cnt       <= w_cnt_nxt;
            r_val       <= w_val_nxt;
            r_valid     <= w_valid_nxt;
            r_err       <= w_err_nxt;
            r_to        <= w_to_nxt;
        end
    end

    assign disp_digits = r_buf;
    assign digit_count = r_cnt;
    assign entry_value = r_val;
    assign entry_valid = r_valid;
    assign key_err     = r_err;
    assign timeout     = r_to;
    assign dbg_state   = r_state;
endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: directed steps plus random keys against a digit-queue model.
// Define KEYPAD_ENTRY_TIMEOUT_EN for both files to also cover the auto-clear path.
module tb_keypad_entry;
    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   enc_out;
    logic         pressed;
    logic [W-1:0] disp_digits;
    logic [2:0]   digit_count;
    logic [W-1:0] entry_value;
    logic         entry_valid;
    logic         entry_ready;
    logic         key_err;
    logic         timeout;
    logic [1:0]   dbg_state;

    keypad_entry #(.DIGITS(DIGITS), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .enc_out(enc_out), .pressed(pressed),
        .disp_digits(disp_digits), .digit_count(digit_count),
        .entry_value(entry_value), .entry_valid(entry_valid),
        .entry_ready(entry_ready), .key_err(key_err), .timeout(timeout),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: typed digits oldest-first, plus committed entries awaiting hand-off.
    int           q[$];
    bit           m_done;
    logic [W-1:0] exp_q[$];

    function automatic logic [W-1:0] pack();
        logic [W-1:0] v = '0;
        foreach (q[i]) v = v * 16 + W'(q[i]);
        return v;
    endfunction

    function automatic bit model_key(input logic [3:0] code);
        if (m_done) return 1'b1;
        if (code <= 4'h9) begin
            if (q.size() < DIGITS) begin q.push_back(int'(code)); return 1'b0; end
            return 1'b1;
        end
        if (code == 4'hA) begin
            if (q.size() > 0) begin void'(q.pop_back()); return 1'b0; end
            return 1'b1;
        end
        if (code == 4'hB) begin q.delete(); return 1'b0; end
        if (code == 4'hE) begin
            if (q.size() == 0) return 1'b1;
            exp_q.push_back(pack());
            m_done = 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [1:0] exp_state();
        if (m_done) return 2'd2;
        return (q.size() > 0) ? 2'd1 : 2'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input bit exp_err);
        chk({tag, ".disp"},  32'(disp_digits), 32'(pack()));
        chk({tag, ".count"}, 32'(digit_count), 32'(q.size()));
        chk({tag, ".err"},   32'(key_err),     32'(exp_err));
        chk({tag, ".valid"}, 32'(entry_valid), 32'(m_done));
        chk({tag, ".state"}, 32'(dbg_state),   32'(exp_state()));
        chk({tag, ".to"},    32'(timeout),     32'd0);
        if (m_done) chk({tag, ".value"}, 32'(entry_value), 32'(exp_q[0]));
    endtask

    task automatic press_key(input logic [3:0] code, input int rel);
        bit e;
        @(negedge clk);
        enc_out = code;
        pressed = 1'b1;
        e = model_key(code);
        @(negedge clk);
        check_all("press", e);
        @(negedge clk);
        chk("err_pulse", 32'(key_err), 32'd0);
        pressed = 1'b0;
        enc_out = 4'($urandom_range(0, 15));
        repeat (rel) @(negedge clk);
    endtask

    task automatic accept();
        @(negedge clk);
        entry_ready = 1'b1;
        chk("acc.value", 32'(entry_value), 32'(exp_q.pop_front()));
        @(negedge clk);
        entry_ready = 1'b0;
        m_done = 1'b0;
        q.delete();
        check_all("accept", 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q.delete();
        exp_q.delete();
        m_done = 1'b0;
    endtask

    initial begin
        pressed     = 1'b1;
        enc_out     = 4'h5;
        entry_ready = 1'b0;
        m_done      = 1'b0;

        // Key held across reset must not strobe.
        do_reset();
        repeat (3) begin
            @(negedge clk);
            check_all("held_reset", 1'b0);
        end
        pressed = 1'b0;
        repeat (2) @(negedge clk);

        press_key(4'h1, 1); press_key(4'h2, 1); press_key(4'h3, 1);
        chk("d123", 32'(disp_digits), 32'h0123);
        press_key(4'hA, 2);
        chk("d12", 32'(disp_digits), 32'h0012);
        press_key(4'hB, 1);

        repeat (5) press_key(4'h9, 1);
        chk("d9999", 32'(disp_digits), 32'h9999);
        press_key(4'hB, 1);

        press_key(4'h4, 1); press_key(4'h2, 1); press_key(4'hE, 1);
        repeat (10) begin
            @(negedge clk);
            chk("hold.valid", 32'(entry_valid), 32'd1);
            chk("hold.value", 32'(entry_value), 32'h0042);
        end
        press_key(4'h7, 2);
        accept();

        press_key(4'hE, 1);
        press_key(4'h5, 1); press_key(4'h6, 1); press_key(4'hB, 1);
        press_key(4'h8, 1);
        press_key(4'hC, 1); press_key(4'hD, 1); press_key(4'hF, 1);
        press_key(4'hA, 1); press_key(4'hA, 1);

        // Key strobe in the same cycle as the hand-off: dropped with an error.
        press_key(4'h3, 1); press_key(4'hE, 1);
        @(negedge clk);
        enc_out = 4'h7; pressed = 1'b1; entry_ready = 1'b1;
        chk("same.value", 32'(entry_value), 32'(exp_q.pop_front()));
        @(negedge clk);
        entry_ready = 1'b0; m_done = 1'b0; q.delete();
        check_all("same_cycle", 1'b1);
        pressed = 1'b0;
        repeat (2) @(negedge clk);

        // Reset while an entry is pending discards it.
        press_key(4'h6, 1); press_key(4'hE, 1);
        do_reset();
        @(negedge clk);
        check_all("rst_done", 1'b0);
        chk("rst_done.value", 32'(entry_value), 32'd0);

        for (int n = 0; n < 250; n++) begin
            int r;
            logic [3:0] code;
            if (m_done && $urandom_range(0, 2) == 0) begin
                accept();
            end else begin
                r = int'($urandom_range(0, 19));
                code = (r < 16) ? 4'(r) : ((r < 18) ? 4'hE : 4'hA);
                press_key(code, int'($urandom_range(1, 4)));
            end
        end
        if (m_done) accept();

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
        press_key(4'hB, 1);
        @(negedge clk);
        enc_out = 4'h3; pressed = 1'b1;
        void'(model_key(4'h3));
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 2) pressed = 1'b0;
            if (k == 17) q.delete();
            chk("to.pulse", 32'(timeout), 32'(k == 17));
            chk("to.disp", 32'(disp_digits), 32'(pack()));
        end
        chk("to.state", 32'(dbg_state), 32'd0);

        @(negedge clk);
        enc_out = 4'h3; pressed = 1'b1;
        void'(model_key(4'h3));
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 2) pressed = 1'b0;
            if (k == 16) begin
                enc_out = 4'h5; pressed = 1'b1;
                void'(model_key(4'h5));
            end
            if (k == 18) pressed = 1'b0;
            chk("term.to", 32'(timeout), 32'd0);
            chk("term.disp", 32'(disp_digits), 32'(pack()));
        end
        chk("term.d35", 32'(disp_digits), 32'h0035);
        press_key(4'hB, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
